instr_fetch: RTL and testbench

Instruction fetch stage directly upstream of the banked instruction memory. Holds the program counter and splits it into the memory's row/column address halves. Absorbs the memory's one-cycle registered read latency with a small skid buffer, and presents instructions to decode over a valid/ready handshake with redirect (branch/jump) support. An optional loader path writes program words into the memory before fetch begins.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/instr_fetch_if.sv | 27 ++
 rtl/fetch_skid_buf.sv | 59 +++++
 rtl/instr_fetch.sv | 135 +++++++++++++
 tb/tb_instr_fetch.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction fetch stage.
// Loader-related state is used only with INSTR_FETCH_LOADER_EN.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 8;
  localparam int FETCH_DATA_W = 32;
  localparam int unsigned FETCH_RESET_PC = 0;

  typedef enum logic {
    FETCH_LOAD,
    FETCH_RUN
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_DATA_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: fetch-to-decode valid/ready instruction handshake.
// Fetch drives the master side, decode the slave side.
interface instr_fetch_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 8
);

  logic                  Instr_valid;
  logic                  Instr_ready;
  logic [DATA_WIDTH-1:0] Instr;
  logic [ADDR_BITS-1:0]  Instr_pc;

  modport master (
    output Instr_valid,
    output Instr,
    output Instr_pc,
    input  Instr_ready
  );

  modport slave (
    input  Instr_valid,
    input  Instr,
    input  Instr_pc,
    output Instr_ready
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: small FIFO of {instr, pc} absorbing memory read latency.
// Flush empties it; simultaneous push and pop on a full buffer is legal.
module fetch_skid_buf #(
  parameter int DW    = 32,
  parameter int AW    = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_instr,
  input  logic [AW-1:0] push_pc,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic [DW-1:0] head_instr,
  output logic [AW-1:0] head_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DW-1:0] buf_instr [DEPTH];
  logic [AW-1:0] buf_pc    [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      buf_instr[wr_ptr] <= push_instr;
      buf_pc[wr_ptr]    <= push_pc;
    end
  end

  assign head_instr = buf_instr[rd_ptr];
  assign head_pc    = buf_pc[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, row/column memory address, skid buffer, decode handshake.
// Program loader path enabled by defining INSTR_FETCH_LOADER_EN.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_BITS  = FETCH_ADDR_W,
  parameter int DATA_WIDTH = FETCH_DATA_W,
  parameter logic [ADDR_BITS-1:0] RESET_PC =
    ADDR_BITS'(FETCH_RESET_PC),
  parameter int BUF_DEPTH  = 2
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  output logic                   Mem_WriteEnable,
  output logic [ADDR_BITS/2-1:0] Mem_X_addr,
  output logic [ADDR_BITS/2-1:0] Mem_Y_addr,
  output logic [DATA_WIDTH-1:0]  Mem_Data_in,
  input  logic [DATA_WIDTH-1:0]  Mem_Data_out,
  input  logic                   Redirect_valid,
  input  logic [ADDR_BITS-1:0]   Redirect_pc,
`ifdef INSTR_FETCH_LOADER_EN
  input  logic                   Load_valid,
  input  logic [ADDR_BITS-1:0]   Load_addr,
  input  logic [DATA_WIDTH-1:0]  Load_data,
  input  logic                   Load_done,
`endif
  instr_fetch_if.master          dec
);

  localparam int HALF = ADDR_BITS / 2;
  localparam int CW   = $clog2(BUF_DEPTH + 1);
  localparam int OW   = CW + 1;

`ifdef INSTR_FETCH_LOADER_EN
  localparam fetch_state_e BOOT = FETCH_LOAD;
`else
  localparam fetch_state_e BOOT = FETCH_RUN;
`endif

  fetch_state_e          state;
  logic [ADDR_BITS-1:0]  pc;
  logic                  fl_valid;
  logic [ADDR_BITS-1:0]  fl_pc;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] head_instr;
  logic [ADDR_BITS-1:0]  head_pc;
  logic                  run;
  logic                  redirect;
  logic                  valid;
  logic                  pop;
  logic                  issue;
  logic [OW-1:0]         occ;
  logic [ADDR_BITS-1:0]  addr;
  logic                  we;
  logic [DATA_WIDTH-1:0] wd;

  assign run      = (state == FETCH_RUN);
  assign redirect = run && Redirect_valid;
  assign valid    = (count != '0);
  assign pop      = valid && dec.Instr_ready;

  // Occupancy after this cycle's pop, so a full-rate stream keeps issuing.
  assign occ   = OW'(count) + OW'(fl_valid) - OW'(pop);
  assign issue = run && !Redirect_valid && (occ < OW'(BUF_DEPTH));

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      fl_valid <= 1'b0;
      fl_pc    <= '0;
    end else begin
      case (state)
        FETCH_RUN: begin
          if (redirect)   pc <= Redirect_pc;
          else if (issue) pc <= pc + 1'b1;
          fl_valid <= issue;
          fl_pc    <= pc;
        end
        FETCH_LOAD: begin
`ifdef INSTR_FETCH_LOADER_EN
          if (Load_done) begin
            state <= FETCH_RUN;
            pc    <= RESET_PC;
          end
`else
          state <= FETCH_RUN;
`endif
        end
        default: state <= FETCH_RUN;
      endcase
    end
  end

  always_comb begin
    addr = pc;
    we   = 1'b0;
    wd   = '0;
`ifdef INSTR_FETCH_LOADER_EN
    if (state == FETCH_LOAD && Load_valid) begin
      addr = Load_addr;
      we   = 1'b1;
      wd   = Load_data;
    end
`endif
  end

  assign Mem_WriteEnable = we;
  assign Mem_Data_in     = wd;
  assign Mem_X_addr      = addr[ADDR_BITS-1:HALF];
  assign Mem_Y_addr      = addr[HALF-1:0];

  fetch_skid_buf #(
    .DW    (DATA_WIDTH),
    .AW    (ADDR_BITS),
    .DEPTH (BUF_DEPTH),
    .CW    (CW)
  ) u_buf (
    .clk        (Clock),
    .rst_n      (Reset_n),
    .flush      (redirect),
    .push       (fl_valid),
    .push_instr (Mem_Data_out),
    .push_pc    (fl_pc),
    .pop        (pop),
    .count      (count),
    .head_instr (head_instr),
    .head_pc    (head_pc)
  );

  assign dec.Instr_valid = valid;
  assign dec.Instr       = valid ? head_instr : '0;
  assign dec.Instr_pc    = valid ? head_pc : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scoreboard bench for instr_fetch.
// Loader phase runs only when INSTR_FETCH_LOADER_EN is defined.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int HW = AW / 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we0, we1;
  logic [HW-1:0] x0, y0, x1, y1;
  logic [DW-1:0] din0, din1;
  logic [DW-1:0] dout0 = '0;
  logic [DW-1:0] dout1 = '0;
  logic          rv0 = 1'b0;
  logic [AW-1:0] rpc0 = '0;
  logic          rv1 = 1'b0;
  logic [AW-1:0] rpc1 = '0;
`ifdef INSTR_FETCH_LOADER_EN
  logic          lv = 1'b0;
  logic          ld = 1'b0;
  logic [AW-1:0] la = '0;
  logic [DW-1:0] ldat = '0;
`endif

  logic [DW-1:0] mem0 [256];
  logic [DW-1:0] mem1 [256];
  bit            wr0 [256];
  bit            wr1 [256];
  logic [DW-1:0] model0 [256];
  logic [DW-1:0] model1 [256];

  fetch_entry_t sb0 [$];
  fetch_entry_t sb1 [$];
  int n_pass = 0;
  int n_total = 0;

  instr_fetch_if #(.DATA_WIDTH(DW), .ADDR_BITS(AW)) dec0 ();
  instr_fetch_if #(.DATA_WIDTH(DW), .ADDR_BITS(AW)) dec1 ();

  instr_fetch #(
    .ADDR_BITS(AW), .DATA_WIDTH(DW),
    .RESET_PC(8'h00), .BUF_DEPTH(2)
  ) u0 (
    .Clock(clk), .Reset_n(rst_n),
    .Mem_WriteEnable(we0),
    .Mem_X_addr(x0), .Mem_Y_addr(y0),
    .Mem_Data_in(din0), .Mem_Data_out(dout0),
    .Redirect_valid(rv0), .Redirect_pc(rpc0),
`ifdef INSTR_FETCH_LOADER_EN
    .Load_valid(lv), .Load_addr(la),
    .Load_data(ldat), .Load_done(ld),
`endif
    .dec(dec0)
  );

  instr_fetch #(
    .ADDR_BITS(AW), .DATA_WIDTH(DW),
    .RESET_PC(8'hFE), .BUF_DEPTH(2)
  ) u1 (
    .Clock(clk), .Reset_n(rst_n),
    .Mem_WriteEnable(we1),
    .Mem_X_addr(x1), .Mem_Y_addr(y1),
    .Mem_Data_in(din1), .Mem_Data_out(dout1),
    .Redirect_valid(rv1), .Redirect_pc(rpc1),
`ifdef INSTR_FETCH_LOADER_EN
    .Load_valid(lv), .Load_addr(la),
    .Load_data(ldat), .Load_done(ld),
`endif
    .dec(dec1)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] initword(input int a);
    if (a < 4) return 32'h1111_1111 * 32'(a + 1);
    return {24'h5A5A5A, 8'(a)};
  endfunction

  always @(posedge clk) begin
    if (we0) begin
      mem0[{x0, y0}] <= din0;
      wr0[{x0, y0}]  <= 1'b1;
    end
    dout0 <= wr0[{x0, y0}] ? mem0[{x0, y0}]
                           : initword(int'({x0, y0}));
  end

  always @(posedge clk) begin
    if (we1) begin
      mem1[{x1, y1}] <= din1;
      wr1[{x1, y1}]  <= 1'b1;
    end
    dout1 <= wr1[{x1, y1}] ? mem1[{x1, y1}]
                           : initword(int'({x1, y1}));
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic push0(input int p);
    fetch_entry_t e;
    e.pc    = 8'(p);
    e.instr = model0[8'(p)];
    sb0.push_back(e);
  endtask

  task automatic push1(input int p);
    fetch_entry_t e;
    e.pc    = 8'(p);
    e.instr = model1[8'(p)];
    sb1.push_back(e);
  endtask

  // Score this cycle's handshakes, then advance one clock.
  task automatic tick();
    fetch_entry_t e;
    dec1.Instr_ready = (sb1.size() != 0);
    if (dec0.Instr_valid && dec0.Instr_ready) begin
      if (sb0.size() == 0) begin
        chk("u0_extra_hs", 32'(dec0.Instr_valid), 32'd0);
      end else begin
        e = sb0.pop_front();
        chk("u0_instr", dec0.Instr, e.instr);
        chk("u0_pc", 32'(dec0.Instr_pc), 32'(e.pc));
      end
    end
    if (dec1.Instr_valid && dec1.Instr_ready) begin
      if (sb1.size() == 0) begin
        chk("u1_extra_hs", 32'(dec1.Instr_valid), 32'd0);
      end else begin
        e = sb1.pop_front();
        chk("u1_instr", dec1.Instr, e.instr);
        chk("u1_pc", 32'(dec1.Instr_pc), 32'(e.pc));
      end
    end
    @(posedge clk);
    #1;
  endtask

`ifdef INSTR_FETCH_LOADER_EN
  task automatic load_phase();
    for (int i = 0; i < 4; i++) begin
      lv   = 1'b1;
      la   = 8'(i);
      ldat = 32'hA0 + 32'(i);
      model0[i] = ldat;
      model1[i] = ldat;
      #1;
      chk("ld_we", 32'(we0), 32'd1);
      chk("ld_addr", 32'({x0, y0}), 32'(i));
      chk("ld_data", din0, ldat);
      chk("ld_valid", 32'(dec0.Instr_valid), 32'd0);
      tick();
    end
    lv   = 1'b0;
    ld   = 1'b1;
    rv0  = 1'b1;
    rpc0 = 8'h40;
    #1;
    chk("ld_done_valid", 32'(dec0.Instr_valid), 32'd0);
    chk("ld_done_we", 32'(we0), 32'd0);
    tick();
    ld  = 1'b0;
    rv0 = 1'b0;
  endtask
`endif

  task automatic start_run();
    chk("c0_valid", 32'(dec0.Instr_valid), 32'd0);
    tick();
    chk("c1_valid", 32'(dec0.Instr_valid), 32'd0);
    tick();
    chk("c2_valid", 32'(dec0.Instr_valid), 32'd1);
    chk("c2_valid_u1", 32'(dec1.Instr_valid), 32'd1);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      model0[a] = initword(a);
      model1[a] = initword(a);
    end
    dec0.Instr_ready = 1'b1;
    dec1.Instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(dec0.Instr_valid), 32'd0);
    chk("rst_instr", dec0.Instr, 32'd0);
    chk("rst_ipc", 32'(dec0.Instr_pc), 32'd0);
    chk("rst_we", 32'(we0), 32'd0);
    chk("rst_din", din0, 32'd0);
    chk("rst_addr", 32'({x0, y0}), 32'h00);
    chk("rst_addr_u1", 32'({x1, y1}), 32'hFE);
    chk("rst_valid_u1", 32'(dec1.Instr_valid), 32'd0);

    rst_n = 1'b1;
`ifdef INSTR_FETCH_LOADER_EN
    load_phase();
`endif
    for (int p = 0; p <= 8; p++) push0(p);
    push1(8'hFE);
    push1(8'hFF);
    push1(8'h00);
    push1(8'h01);
    start_run();
    repeat (5) tick();

    dec0.Instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_valid", 32'(dec0.Instr_valid), 32'd1);
      chk("stall_pc", 32'(dec0.Instr_pc), 32'd5);
      chk("stall_instr", dec0.Instr, model0[5]);
      chk("stall_addr", 32'({x0, y0}), 32'd7);
      tick();
    end
    dec0.Instr_ready = 1'b1;
    repeat (3) tick();

    rv0  = 1'b1;
    rpc0 = 8'h40;
    tick();
    rv0 = 1'b0;
    sb0.delete();
    for (int p = 8'h40; p <= 8'h43; p++) push0(p);
    chk("redir_t1_valid", 32'(dec0.Instr_valid), 32'd0);
    chk("redir_t1_addr", 32'({x0, y0}), 32'h40);
    tick();
    chk("redir_t2_valid", 32'(dec0.Instr_valid), 32'd0);
    tick();
    chk("redir_t3_valid", 32'(dec0.Instr_valid), 32'd1);
    repeat (4) tick();

    dec0.Instr_ready = 1'b0;
    repeat (2) tick();
    chk("full_valid", 32'(dec0.Instr_valid), 32'd1);
    chk("full_pc", 32'(dec0.Instr_pc), 32'h44);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(dec0.Instr_valid), 32'd0);
    chk("midrst_instr", dec0.Instr, 32'd0);
    chk("midrst_ipc", 32'(dec0.Instr_pc), 32'd0);
    chk("midrst_addr", 32'({x0, y0}), 32'h00);
    chk("midrst_addr_u1", 32'({x1, y1}), 32'hFE);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb0.delete();
    sb1.delete();
    dec0.Instr_ready = 1'b1;
`ifdef INSTR_FETCH_LOADER_EN
    load_phase();
`endif
    for (int p = 0; p < 4; p++) push0(p);
    push1(8'hFE);
    push1(8'hFF);
    push1(8'h00);
    push1(8'h01);
    start_run();
    repeat (4) tick();
    dec0.Instr_ready = 1'b0;
    chk("drain_u0", 32'(sb0.size()) | 32'(dec0.Instr_pc != 8'd4), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
